// File: rtl/svx32_mem_rsp_if.sv
// Load/store handshake between the svx32 memory unit (master) and the
// data-memory responder (slave).
interface svx32_mem_rsp_if #(
  parameter int MAX_LAT = 3
);
  localparam int LW = $clog2(MAX_LAT + 1);

  logic          pil_mem_req;
  logic          pil_mem_wen;
  logic [31:0]   pil_mem_addr_unused_guard;
  logic [31:0]   piv_mem_addr;
  logic [31:0]   piv_mem_wdata;
  logic [3:0]    piv_mem_byte_sel;
  logic [LW-1:0] piv_lat;
  logic          pol_mem_ack;
  logic          pol_mem_valid;
  logic [31:0]   pov_mem_rdata;
  logic          pol_mem_err;
  logic          pol_busy;

  modport master (
    output pil_mem_req, pil_mem_wen, piv_mem_addr, piv_mem_wdata,
           piv_mem_byte_sel, piv_lat,
    input  pol_mem_ack, pol_mem_valid, pov_mem_rdata, pol_mem_err, pol_busy
  );

  modport slave (
    input  pil_mem_req, pil_mem_wen, piv_mem_addr, piv_mem_wdata,
           piv_mem_byte_sel, piv_lat,
    output pol_mem_ack, pol_mem_valid, pov_mem_rdata, pol_mem_err, pol_busy
  );
endinterface

// File: rtl/svx32_mem_rsp.sv
// Data-memory responder for the svx32 load/store handshake with per-transaction
// latency and a byte-lane backing store. SVX32_MEM_RSP_ZERO_INIT_EN adds a zeroing sweep after reset.
module svx32_mem_rsp #(
  parameter int DEPTH   = 256,
  parameter int MAX_LAT = 3
) (
  input  logic            pil_clk,
  input  logic            pil_rst,
  svx32_mem_rsp_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(MAX_LAT + 1);

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_t;

`ifdef SVX32_MEM_RSP_ZERO_INIT_EN
  localparam state_t RST_STATE = ST_INIT;
  localparam logic   RST_BUSY  = 1'b1;
  logic [AW-1:0] ptr_r;
`else
  localparam state_t RST_STATE = ST_IDLE;
  localparam logic   RST_BUSY  = 1'b0;
`endif

  state_t        state_r, state_s;
  logic [LW-1:0] cnt_r, cnt_s, lat_sat_s;
  logic          accept_s, enter_resp_s, store_s;
  logic [31:0]   addr_r, wdata_r;
  logic          wen_r;
  logic [3:0]    sel_r;
  logic [31:0]   acc_addr_s, acc_wdata_s;
  logic          acc_wen_s, acc_err_s;
  logic [3:0]    acc_sel_s;
  logic [AW-1:0] acc_idx_s;
  logic          rsp_err_r;
  logic [31:0]   rsp_data_r;
  logic          ack_r, valid_r, err_r, busy_r;
  logic [31:0]   rdata_r;
  logic [31:0]   mem_r [DEPTH];

  // Out-of-range word address or an empty lane mask rejects the access.
  function automatic logic access_err(input logic [31:0] addr, input logic [3:0] sel);
    access_err = ((addr >> (AW + 2)) != 32'd0) || (sel == 4'b0000);
  endfunction

  if (((1 << LW) - 1) > MAX_LAT) begin : g_lat_sat
    assign lat_sat_s = (bus.piv_lat > LW'(MAX_LAT)) ? LW'(MAX_LAT) : bus.piv_lat;
  end else begin : g_lat_pass
    assign lat_sat_s = bus.piv_lat;
  end

  assign accept_s = (state_r == ST_IDLE) && bus.pil_mem_req;

  // Zero-latency accepts enter RESP on the accept edge, so take fields straight off the bus.
  always_comb begin
    acc_addr_s  = addr_r;
    acc_wdata_s = wdata_r;
    acc_wen_s   = wen_r;
    acc_sel_s   = sel_r;
    if (state_r == ST_IDLE) begin
      acc_addr_s  = bus.piv_mem_addr;
      acc_wdata_s = bus.piv_mem_wdata;
      acc_wen_s   = bus.pil_mem_wen;
      acc_sel_s   = bus.piv_mem_byte_sel;
    end else begin
      acc_addr_s  = addr_r;
    end
    acc_idx_s = acc_addr_s[AW+1:2];
    acc_err_s = access_err(acc_addr_s, acc_sel_s);
    store_s   = enter_resp_s && acc_wen_s && !acc_err_s;
  end

  // Next-state, latency counter and RESP-entry strobe.
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r;
    enter_resp_s = 1'b0;
    case (state_r)
      ST_INIT: begin
`ifdef SVX32_MEM_RSP_ZERO_INIT_EN
        if (ptr_r == AW'(DEPTH - 1)) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_INIT;
        end
`else
        state_s = ST_IDLE;
`endif
      end
      ST_IDLE: begin
        if (bus.pil_mem_req) begin
          cnt_s = lat_sat_s;
          if (lat_sat_s == LW'(0)) begin
            state_s      = ST_RESP;
            enter_resp_s = 1'b1;
          end else begin
            state_s = ST_WAIT;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        cnt_s = cnt_r - LW'(1);
        if (cnt_r == LW'(1)) begin
          state_s      = ST_RESP;
          enter_resp_s = 1'b1;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_RESP: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Control state, captured request and registered response outputs.
  always_ff @(posedge pil_clk or posedge pil_rst) begin
    if (pil_rst) begin
      state_r    <= RST_STATE;
      cnt_r      <= LW'(0);
      addr_r     <= 32'd0;
      wdata_r    <= 32'd0;
      wen_r      <= 1'b0;
      sel_r      <= 4'b0000;
      rsp_err_r  <= 1'b0;
      rsp_data_r <= 32'd0;
      ack_r      <= 1'b0;
      valid_r    <= 1'b0;
      err_r      <= 1'b0;
      rdata_r    <= 32'd0;
      busy_r     <= RST_BUSY;
`ifdef SVX32_MEM_RSP_ZERO_INIT_EN
      ptr_r      <= AW'(0);
`endif
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      ack_r   <= accept_s;
      busy_r  <= (state_s != ST_IDLE);
      valid_r <= (state_r == ST_RESP);
      err_r   <= (state_r == ST_RESP) ? rsp_err_r : 1'b0;
      rdata_r <= (state_r == ST_RESP) ? rsp_data_r : 32'd0;
      if (accept_s) begin
        addr_r  <= bus.piv_mem_addr;
        wdata_r <= bus.piv_mem_wdata;
        wen_r   <= bus.pil_mem_wen;
        sel_r   <= bus.piv_mem_byte_sel;
      end
      if (enter_resp_s) begin
        rsp_err_r  <= acc_err_s;
        rsp_data_r <= (!acc_wen_s && !acc_err_s) ? mem_r[acc_idx_s] : 32'd0;
      end
`ifdef SVX32_MEM_RSP_ZERO_INIT_EN
      if (state_r == ST_INIT) begin
        ptr_r <= ptr_r + AW'(1);
      end
`endif
    end
  end

  // Backing store: never reset; reset only blocks writes while asserted.
  always_ff @(posedge pil_clk) begin
    if (!pil_rst) begin
`ifdef SVX32_MEM_RSP_ZERO_INIT_EN
      if (state_r == ST_INIT) begin
        mem_r[ptr_r] <= 32'd0;
      end else if (store_s) begin
`else
      if (store_s) begin
`endif
        for (int i = 0; i < 4; i++) begin
          if (acc_sel_s[i]) begin
            mem_r[acc_idx_s][8*i +: 8] <= acc_wdata_s[8*i +: 8];
          end
        end
      end
    end
  end

  assign bus.pol_mem_ack   = ack_r;
  assign bus.pol_mem_valid = valid_r;
  assign bus.pov_mem_rdata = rdata_r;
  assign bus.pol_mem_err   = err_r;
  assign bus.pol_busy      = busy_r;
endmodule

// File: tb/tb_svx32_mem_rsp.sv
// Directed self-checking bench for svx32_mem_rsp (DEPTH=16, MAX_LAT=3);
// follows SVX32_MEM_RSP_ZERO_INIT_EN when it is defined.
module tb_svx32_mem_rsp;
  localparam int DEPTH = 16;

`ifdef SVX32_MEM_RSP_ZERO_INIT_EN
  localparam logic BUSY_RST = 1'b1;
`else
  localparam logic BUSY_RST = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc_n   = 0;

  svx32_mem_rsp_if #(.MAX_LAT(3)) bus ();

  svx32_mem_rsp #(.DEPTH(DEPTH), .MAX_LAT(3)) dut (
    .pil_clk (clk),
    .pil_rst (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request and follow it to its completion pulse.
  task automatic xact(input string tag, input logic wen, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] sel, input logic [1:0] lat,
                      input logic hold, input int exp_gap, input logic exp_err,
                      input logic [31:0] exp_rdata, output int ack_at);
    int gap;
    int extra;
    int dirty;
    bus.pil_mem_req      = 1'b1;
    bus.pil_mem_wen      = wen;
    bus.piv_mem_addr     = addr;
    bus.piv_mem_wdata    = wdata;
    bus.piv_mem_byte_sel = sel;
    bus.piv_lat          = lat;
    cyc();
    ack_at = cyc_n;
    chk({tag, ".ack"}, {31'd0, bus.pol_mem_ack}, 32'd1);
    chk({tag, ".busy"}, {31'd0, bus.pol_busy}, 32'd1);
    if (!hold) begin
      bus.pil_mem_req      = 1'b0;
      bus.piv_mem_addr     = 32'hFFFF_FFF0;
      bus.piv_mem_wdata    = 32'h0;
      bus.piv_mem_byte_sel = 4'b0000;
    end
    gap = 0;
    extra = 0;
    dirty = 0;
    while (gap < 12) begin
      cyc();
      gap++;
      if (bus.pol_mem_valid) break;
      if (bus.pol_mem_ack) extra++;
      if (bus.pov_mem_rdata !== 32'd0 || bus.pol_mem_err !== 1'b0) dirty++;
    end
    bus.pil_mem_req = 1'b0;
    chk({tag, ".gap"}, 32'(gap), 32'(exp_gap));
    chk({tag, ".extra_ack"}, 32'(extra), 32'd0);
    chk({tag, ".idle_rdata"}, 32'(dirty), 32'd0);
    chk({tag, ".err"}, {31'd0, bus.pol_mem_err}, {31'd0, exp_err});
    chk({tag, ".rdata"}, bus.pov_mem_rdata, exp_rdata);
    chk({tag, ".busy_done"}, {31'd0, bus.pol_busy}, 32'd0);
  endtask

  initial begin
    int a0;
    int a1;
    int n;
    int acks;
    bus.pil_mem_req      = 1'b0;
    bus.pil_mem_wen      = 1'b0;
    bus.piv_mem_addr     = 32'h0;
    bus.piv_mem_wdata    = 32'h0;
    bus.piv_mem_byte_sel = 4'b0000;
    bus.piv_lat          = 2'd0;
    rst = 1'b1;
    cyc();
    cyc();
    chk("rst.ack", {31'd0, bus.pol_mem_ack}, 32'd0);
    chk("rst.valid", {31'd0, bus.pol_mem_valid}, 32'd0);
    chk("rst.rdata", bus.pov_mem_rdata, 32'd0);
    chk("rst.err", {31'd0, bus.pol_mem_err}, 32'd0);
    chk("rst.busy", {31'd0, bus.pol_busy}, {31'd0, BUSY_RST});
    rst = 1'b0;

`ifdef SVX32_MEM_RSP_ZERO_INIT_EN
    bus.pil_mem_req = 1'b1;
    n = 0;
    acks = 0;
    while (n < 40) begin
      cyc();
      n++;
      if (bus.pol_mem_ack) acks++;
      if (!bus.pol_busy) break;
    end
    bus.pil_mem_req = 1'b0;
    chk("init.busy_cycles", 32'(n), 32'd16);
    chk("init.no_ack", 32'(acks), 32'd0);
    xact("init.ld", 1'b0, 32'h10, 32'h0, 4'hF, 2'd1, 1'b0, 2, 1'b0, 32'h0, a0);
`endif

    xact("st_l2", 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 2'd2, 1'b0, 3, 1'b0, 32'h0, a0);
    xact("ld_l1", 1'b0, 32'h10, 32'h0, 4'hF, 2'd1, 1'b0, 2, 1'b0, 32'hDEAD_BEEF, a0);

    xact("st_base", 1'b1, 32'h20, 32'h1122_3344, 4'hF, 2'd0, 1'b0, 1, 1'b0, 32'h0, a0);
    xact("st_lane0", 1'b1, 32'h20, 32'h0000_00AB, 4'b0001, 2'd0, 1'b0, 1, 1'b0, 32'h0, a0);
    xact("ld_lane0", 1'b0, 32'h20, 32'h0, 4'hF, 2'd0, 1'b0, 1, 1'b0, 32'h1122_33AB, a1);
    chk("l0.spacing", 32'(a1 - a0), 32'd2);

    xact("ld_l3_hold", 1'b0, 32'h10, 32'h0, 4'hF, 2'd3, 1'b1, 4, 1'b0, 32'hDEAD_BEEF, a0);

    xact("st_lanes13", 1'b1, 32'h10, 32'h1234_5678, 4'b1010, 2'd2, 1'b0, 3, 1'b0, 32'h0, a0);
    xact("ld_lanes13", 1'b0, 32'h13, 32'h0, 4'hF, 2'd2, 1'b0, 3, 1'b0, 32'h12AD_56EF, a0);

    xact("st_top", 1'b1, 32'h3C, 32'h0BAD_F00D, 4'hF, 2'd1, 1'b0, 2, 1'b0, 32'h0, a0);
    xact("ld_top", 1'b0, 32'h3F, 32'h0, 4'hF, 2'd0, 1'b0, 1, 1'b0, 32'h0BAD_F00D, a0);
    xact("ld_oob", 1'b0, 32'h40, 32'h0, 4'hF, 2'd1, 1'b0, 2, 1'b1, 32'h0, a0);
    xact("st_nosel", 1'b1, 32'h20, 32'hFFFF_FFFF, 4'b0000, 2'd0, 1'b0, 1, 1'b1, 32'h0, a0);
    xact("ld_nosel", 1'b0, 32'h20, 32'h0, 4'hF, 2'd1, 1'b0, 2, 1'b0, 32'h1122_33AB, a0);

    // Reset while the store sits in WAIT: it must never reach memory.
    bus.pil_mem_req      = 1'b1;
    bus.pil_mem_wen      = 1'b1;
    bus.piv_mem_addr     = 32'h20;
    bus.piv_mem_wdata    = 32'hCAFE_F00D;
    bus.piv_mem_byte_sel = 4'hF;
    bus.piv_lat          = 2'd3;
    cyc();
    chk("mid.ack", {31'd0, bus.pol_mem_ack}, 32'd1);
    bus.pil_mem_req = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid.ack_drop", {31'd0, bus.pol_mem_ack}, 32'd0);
    chk("mid.busy_drop", {31'd0, bus.pol_busy}, {31'd0, BUSY_RST});
    chk("mid.valid", {31'd0, bus.pol_mem_valid}, 32'd0);
    cyc();
    cyc();
    rst = 1'b0;
    n = 0;
    acks = 0;
    while (n < 40) begin
      cyc();
      n++;
      if (bus.pol_mem_valid) acks++;
      if (!bus.pol_busy && n >= 5) break;
    end
    chk("mid.no_valid", 32'(acks), 32'd0);
`ifdef SVX32_MEM_RSP_ZERO_INIT_EN
    xact("mid.ld", 1'b0, 32'h20, 32'h0, 4'hF, 2'd1, 1'b0, 2, 1'b0, 32'h0, a0);
`else
    xact("mid.ld", 1'b0, 32'h20, 32'h0, 4'hF, 2'd1, 1'b0, 2, 1'b0, 32'h1122_33AB, a0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
